// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 front end: mode encoding, block geometry,
// padder states and the byte-count to bit-length conversion.
package sha2_pkg;

  localparam logic [1:0] MODE_SHA224 = 2'b00;
  localparam logic [1:0] MODE_SHA256 = 2'b01;
  localparam logic [1:0] MODE_SHA384 = 2'b10;
  localparam logic [1:0] MODE_SHA512 = 2'b11;

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_EMIT_DATA,
    ST_EMIT_PAD1,
    ST_EMIT_PAD2
  } state_t;

  function automatic logic [7:0] blk_bytes(input logic [1:0] mode);
    case (mode)
      MODE_SHA224, MODE_SHA256: blk_bytes = 8'd64;
      MODE_SHA384, MODE_SHA512: blk_bytes = 8'd128;
      default:                  blk_bytes = 8'd64;
    endcase
  endfunction

  function automatic logic [7:0] len_bytes(input logic [1:0] mode);
    len_bytes = (blk_bytes(mode) == 8'd128) ? 8'd16 : 8'd8;
  endfunction

  function automatic logic [63:0] bit_len(input logic [60:0] nbytes);
    bit_len = {nbytes, 3'b000};
  endfunction

endpackage

// File: rtl/sha2_pad_byte_mux.sv
// Per-lane selection of data byte, 0x80 marker, zero or length byte when
// forming a padded block; lane 0 is the first byte (bdata[1023:1016]).
module sha2_pad_byte_mux
  import sha2_pkg::*;
(
  input  logic [1:0]    i_mode,
  input  logic [7:0]    i_ptr,
  input  logic          i_mark,
  input  logic          i_len_en,
  input  logic [63:0]   i_bitlen,
  input  logic [1023:0] i_data,
  output logic [1023:0] o_block
);

  logic [7:0] w_blk;
  logic [7:0] w_len_start;

  assign w_blk       = blk_bytes(i_mode);
  assign w_len_start = w_blk - len_bytes(i_mode);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    o_block = '0;
    for (int i = 0; i < 128; i++) begin
      logic [7:0] lane;
      logic [7:0] shift;
      lane  = 8'(i);
      shift = (w_blk - 8'd1) - lane;
      if (lane >= w_blk) begin
        o_block[1023-8*i -: 8] = 8'h00;
      end else if (i_len_en && lane >= w_len_start) begin
        // Length field is big-endian; bytes beyond the 64-bit value shift out as zero.
        o_block[1023-8*i -: 8] = 8'({64'd0, i_bitlen} >> {shift, 3'b000});
      end else if (lane < i_ptr) begin
        o_block[1023-8*i -: 8] = i_data[1023-8*i -: 8];
      end else if (i_mark && lane == i_ptr) begin
        o_block[1023-8*i -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha2_block_padder.sv
// Byte-stream to padded SHA-2 block converter: buffers beats into a block,
// appends 0x80 / zeros / bit length and hands blocks to the core.
module sha2_block_padder
  import sha2_pkg::*;
#(
  parameter int BEAT_BYTES = 4,
  parameter int ID_W       = 32,
  parameter int LEN_W      = 61
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    tvalid,
  output logic                    tready,
  input  logic                    tlast,
  input  logic [ID_W-1:0]         tid,
  input  logic [8*BEAT_BYTES-1:0] tdata,
  input  logic [BEAT_BYTES-1:0]   tkeep,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1023:0]           bdata,
  output logic                    bfirst,
  output logic                    blast,
  output logic [1:0]              bmode,
  output logic [ID_W-1:0]         bid,
  output logic [LEN_W-1:0]        blen
);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_buf [128];
  logic [7:0]       r_ptr;
  logic [LEN_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic [ID_W-1:0]  r_id;
  logic             r_started, r_sent, r_mark, r_tail;

  logic [1:0]    w_mode_eff;
  logic [7:0]    w_blk, w_lenb, w_nkeep, w_ptr_new;
  logic          w_accept, w_bhs, w_emit, w_blast;
  logic [1023:0] w_buf_flat, w_block;

  // Geometry for the beat in flight comes from the live mode on a message's first beat.
  assign w_mode_eff = r_started ? r_mode : mode;
  assign w_blk      = blk_bytes(w_mode_eff);
  assign w_lenb     = len_bytes(w_mode_eff);
  assign w_ptr_new  = r_ptr + w_nkeep;
  assign w_accept   = !rst && r_state == ST_ACCEPT && tvalid;
  assign w_bhs      = !rst && r_state != ST_ACCEPT && bready;

  always_comb begin
    w_nkeep = '0;
    for (int b = 0; b < BEAT_BYTES; b++) w_nkeep = w_nkeep + 8'(tkeep[b]);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCEPT: begin
        if (tvalid) begin
          if (tlast) begin
            if (w_ptr_new + 8'd1 <= w_blk - w_lenb) w_state_nxt = ST_EMIT_PAD2;
            else if (w_ptr_new == w_blk)            w_state_nxt = ST_EMIT_DATA;
            else                                    w_state_nxt = ST_EMIT_PAD1;
          end else if (w_ptr_new == w_blk) begin
            w_state_nxt = ST_EMIT_DATA;
          end
        end
      end
      ST_EMIT_DATA: if (bready) w_state_nxt = r_tail ? ST_EMIT_PAD2 : ST_ACCEPT;
      ST_EMIT_PAD1: if (bready) w_state_nxt = ST_EMIT_PAD2;
      ST_EMIT_PAD2: if (bready) w_state_nxt = ST_ACCEPT;
      default:                  w_state_nxt = ST_ACCEPT;
    endcase
  end

  // NOTE: sequential state is only ever assigned with <=, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ACCEPT;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the buffer is a small flop array, so it is cleared with everything else; a RAM would not be.
      for (int i = 0; i < 128; i++) r_buf[i] <= 8'h00;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_mode    <= '0;
      r_id      <= '0;
      r_started <= 1'b0;
      r_sent    <= 1'b0;
      r_mark    <= 1'b0;
      r_tail    <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int b = 0; b < BEAT_BYTES; b++)
          if (tkeep[b]) r_buf[7'(r_ptr + 8'(b))] <= tdata[8*b +: 8];
        r_ptr  <= w_ptr_new;
        r_cnt  <= r_cnt + LEN_W'(w_nkeep);
        r_mark <= tlast && (w_ptr_new != w_blk);
        r_tail <= tlast && (w_ptr_new == w_blk);
        if (!r_started) begin
          r_started <= 1'b1;
          r_mode    <= mode;
          r_id      <= tid;
        end
      end
      if (w_bhs) begin
        r_sent <= 1'b1;
        r_ptr  <= '0;
        case (r_state)
          ST_EMIT_DATA: r_mark <= r_tail;
          ST_EMIT_PAD1: r_mark <= 1'b0;
          ST_EMIT_PAD2: begin
            r_cnt     <= '0;
            r_sent    <= 1'b0;
            r_started <= 1'b0;
            r_mark    <= 1'b0;
            r_tail    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_buf_flat = '0;
    for (int i = 0; i < 128; i++) w_buf_flat[1023-8*i -: 8] = r_buf[i];
  end

  sha2_pad_byte_mux u_mux (
    .i_mode   (r_mode),
    .i_ptr    (r_ptr),
    .i_mark   (r_mark),
    .i_len_en (r_state == ST_EMIT_PAD2),
    .i_bitlen (bit_len(61'(r_cnt))),
    .i_data   (w_buf_flat),
    .o_block  (w_block)
  );

  assign w_emit  = !rst && r_state != ST_ACCEPT;
  assign w_blast = w_emit && r_state == ST_EMIT_PAD2;

  assign tready = !rst && r_state == ST_ACCEPT;
  assign bvalid = w_emit;
  assign bdata  = w_emit ? w_block : '0;
  assign bfirst = w_emit && !r_sent;
  assign blast  = w_blast;
  assign bmode  = w_emit ? r_mode : 2'b00;
  assign bid    = w_emit ? r_id : '0;
  assign blen   = w_blast ? r_cnt : '0;

endmodule

// File: doc/sha2_block_padder.md
Name: sha2_block_padder

Overview:
- Front-end for the multi-mode SHA-2 core.
- Accepts a byte stream on a parametrised-width tvalid/tready/tlast bus, with tkeep and a per-message tid.
- Emits FIPS 180-4 padded message blocks: 64-byte blocks for SHA-224/256, 128-byte blocks for SHA-384/512.
- Sits between the host stream interface and the compression engine. It generalises the byte-wide, 256/512-only front end to multi-byte beats, four modes and an explicit block-level handshake.

Parameters:
- BEAT_BYTES, 4: bytes per input beat; legal values 1, 2, 4, 8.
- ID_W, 32: width of the message id.
- LEN_W, 61: width of the message byte counter. Bit length = byte count × 8, which fits 64 bits.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  00 SHA-224, 01 SHA-256, 10 SHA-384, 11 SHA-512. Sampled on the first beat of a message.
- tvalid  in  1  input beat valid.
- tready  out  1  input beat accept.
- tlast  in  1  last beat of the message.
- tid  in  ID_W  message id; valid on the first beat only.
- tdata  in  8*BEAT_BYTES  payload; the first byte in stream order is tdata[7:0].
- tkeep  in  BEAT_BYTES  byte enables.
- bvalid  out  1  padded block valid.
- bready  in  1  block accept from the core.
- bdata  out  1024  block, big-endian. The first byte is bdata[1023:1016]. For 64-byte modes bdata[511:0]=0.
- bfirst  out  1  first block of the message.
- blast  out  1  final block of the message.
- bmode  out  2  mode latched for this message.
- bid  out  ID_W  id latched for this message.
- blen  out  LEN_W  total message byte count; valid when blast=1, else 0.

Behaviour:
- Reset: all outputs 0 while rst=1, including tready. The state machine returns to ACCEPT. The byte pointer, byte counter and buffer are cleared. The id and mode latches are cleared.
- Reset mid-message or mid-block discards everything; no partial block is emitted.
- Block geometry: BLK=64 and LENB=8 for modes 0x/01; BLK=128 and LENB=16 for modes 1x.
- States: ACCEPT, EMIT_DATA, EMIT_PAD1, EMIT_PAD2.
- ACCEPT:
  - tready=1.
  - tkeep must be all ones except on the tlast beat, where it is LSB-contiguous and may be all zero (empty message).
  - On an accepted beat, kept bytes are written at pointer p, p advances by popcount(tkeep), and the counter adds popcount(tkeep).
  - The first beat of a message latches tid and mode; mode/tid changes later in the message are ignored.
  - If p reaches BLK and tlast=0, go to EMIT_DATA.
  - If tlast=1, form padding: write 0x80 at p (p<BLK) and zero the bytes above it.
    - If p+1 <= BLK-LENB: also write bit length = count×8, big-endian, into the last LENB bytes (upper 64 bits zero in 128-bit modes), set blast, and go to EMIT_PAD2.
    - Else: go to EMIT_PAD1 with 0x80 placed. If p==BLK, the data block is emitted first via EMIT_DATA, then a block of 0x80 + zeros + length.
- EMIT_*:
  - bvalid=1 and tready=0.
  - bdata, bfirst, blast, bmode, bid and blen hold stable until bvalid&&bready.
  - On handshake:
    - EMIT_DATA goes to ACCEPT, or to EMIT_PAD1/EMIT_PAD2 if tlast was seen with p==BLK.
    - EMIT_PAD1 goes to EMIT_PAD2; the second block is zeros + length, blast=1.
    - EMIT_PAD2 goes to ACCEPT and clears p, the counter and bfirst tracking.
- Latency: bvalid rises the cycle after the beat that completes a block. With bready=1 a block handshakes that cycle and tready returns the following cycle. A beat never straddles blocks because BLK is a multiple of BEAT_BYTES.
- bfirst=1 only on the first block emitted for a message, including padding-only blocks of an empty message.
- The counter wraps mod 2^LEN_W. This is not checked.

Decomposition:
- Package sha2_pkg holds:
  - mode encoding localparams;
  - the functions blk_bytes(mode) and len_bytes(mode);
  - the state enumeration constants;
  - the byte-count-to-bit-length function.
- Sub-module sha2_pad_byte_mux: combinational per-byte-lane select of data / 0x80 / zero / length byte, driven by p, BLK and LENB. The top holds the FSM, counters, latches and buffer.

Test Plan:
1. "abc", SHA-256, BEAT_BYTES=4: tdata=32'h00636261, tkeep=4'b0111, tlast=1, tid=32'h2561 → one block. bdata[1023:512]=616263800000…00000018, bfirst=blast=1, bid=32'h2561, blen=3.
2. Empty message, SHA-512: tkeep=0, tlast=1 → one 128-byte block. bdata=80 followed by 127 zero bytes, blen=0, bfirst=blast=1.
3. 56-byte SHA-256 message (bytes 00..37) → two blocks. Block 1: data + 0x80 at byte 56, then zeros, blast=0. Block 2: all zero except the last 8 bytes = 00000000000001C0, blast=1.
4. 64-byte SHA-256 message (one full block) → full data block (bfirst=1, blast=0), then block 80 00…0000000000000200 (blast=1, blen=64).
5. Backpressure: bready=0 for 5 cycles during test 1 → bdata/bvalid stable, tready=0 throughout, accepted exactly once when bready=1.
6. Reset and mode: assert rst after 3 beats of a SHA-384 message → no block emitted. Then a 16-byte SHA-384 message (A5×8, 5A×8) → single block, bmode=10, length field ...0080. The same message with mode=11 gives identical bdata and bmode=11.
